// File: rtl/matmul2x2_mult_sequencer.sv
// matmul2x2_mult_sequencer
//
// Computes the 2x2 by 2x2 unsigned matrix product C = A x B on one shared
// combinational IN_W x IN_W multiplier. Eight operand nibbles are loaded
// (A00 A01 A10 A11 B00 B01 B10 B11). The eight partial products then run
// through the multiplier, one per cycle, into four accumulators. The four
// results are streamed out in the order C00, C01, C10, C11.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clr                 synchronous abort back to LOAD
//   in_valid/in_ready   operand nibble handshake, data on in_nibble
//   mul_a, mul_b        operands driven to the external multiplier
//   mul_p               product from the multiplier (same cycle)
//   out_valid/out_ready result handshake, data on out_data, index {i,j} on out_idx
//   busy                high while computing or presenting results
//   done                one-cycle pulse after the last result is accepted
module matmul2x2_mult_sequencer #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned ACC_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_nibble,
    output logic              in_ready,
    output logic [IN_W-1:0]   mul_a,
    output logic [IN_W-1:0]   mul_b,
    input  logic [2*IN_W-1:0] mul_p,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic [1:0]        out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    // The sum of two full-scale products needs one bit beyond the product width.
    if (ACC_W < 2 * IN_W + 1) begin : g_bad_acc_w
        $error("ACC_W must be at least 2*IN_W+1");
    end

    typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2:0]             step_q, step_d;
    logic [1:0]             idx_q, idx_d;
    logic                   done_q, done_d;
    // Operand slots 0..3 hold A (row-major), 4..7 hold B (row-major).
    logic [IN_W-1:0]        slot_q [8];
    logic [IN_W-1:0]        slot_d [8];
    logic [ACC_W-1:0]       acc_q  [4];
    logic [ACC_W-1:0]       acc_d  [4];

    logic [1:0]             step_e;
    logic                   step_k;
    logic [ACC_W-1:0]       prod_ext;

    // step = {i, j, k}: element e = {i, j}, inner index k.
    assign step_e   = step_q[2:1];
    assign step_k   = step_q[0];
    assign prod_ext = {{(ACC_W - 2 * IN_W){1'b0}}, mul_p};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        slot_d  = slot_q;
        acc_d   = acc_q;

        if (clr) begin
            state_d = StLoad;
            cnt_d   = '0;
            step_d  = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        slot_d[cnt_q] = in_nibble;
                        if (cnt_q == 3'd7) begin
                            cnt_d   = '0;
                            step_d  = '0;
                            state_d = StCompute;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                StCompute: begin
                    if (step_k) begin
                        acc_d[step_e] = acc_q[step_e] + prod_ext;
                    end else begin
                        acc_d[step_e] = prod_ext;
                    end
                    if (step_q == 3'd7) begin
                        step_d  = '0;
                        idx_d   = '0;
                        state_d = StOutput;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        if (idx_q == 2'd3) begin
                            idx_d   = '0;
                            done_d  = 1'b1;
                            state_d = StLoad;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            slot_q  <= '{default: '0};
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            slot_q  <= slot_d;
            acc_q   <= acc_d;
        end
    end

    // All outputs decode registered state only.
    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StOutput);
    assign busy      = (state_q != StLoad);
    assign done      = done_q;
    assign out_idx   = idx_q;
    assign out_data  = out_valid ? acc_q[idx_q] : '0;

    // mul_a = A[i][k] -> slot {0,i,k}; mul_b = B[k][j] -> slot {1,k,j}.
    assign mul_a = (state_q == StCompute) ? slot_q[{1'b0, step_q[2], step_q[0]}] : '0;
    assign mul_b = (state_q == StCompute) ? slot_q[{1'b1, step_q[0], step_q[1]}] : '0;

endmodule

// File: tb/tb_matmul2x2_mult_sequencer.sv
// Randomised self-checking bench for matmul2x2_mult_sequencer. The external
// multiplier is modelled behaviourally; expected results come from a plain
// arithmetic matrix product of the loaded operands.
module tb_matmul2x2_mult_sequencer;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned ACC_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic [IN_W-1:0]   in_nibble = '0;
    logic              in_ready;
    logic [IN_W-1:0]   mul_a;
    logic [IN_W-1:0]   mul_b;
    logic [2*IN_W-1:0] mul_p;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic [1:0]        out_idx;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ops [8];

    always #5 clk = ~clk;

    assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

    matmul2x2_mult_sequencer #(
        .IN_W (IN_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_nibble(in_nibble),
        .in_ready (in_ready),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // C[i][j] = sum_k A[i][k] * B[k][j]
    function automatic int unsigned c_ref(input int unsigned idx);
        int unsigned i;
        int unsigned j;
        i = idx / 2;
        j = idx % 2;
        return ops[i*2] * ops[4 + j] + ops[i*2 + 1] * ops[4 + 2 + j];
    endfunction

    task automatic set_ops_test1();
        for (int n = 0; n < 8; n++) ops[n] = n + 1;
    endtask

    task automatic set_ops_random();
        for (int n = 0; n < 8; n++) ops[n] = $urandom_range(15, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  in_ready,  1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_data"},  out_data,  0);
        check_eq({tag, "_out_idx"},   out_idx,   0);
        check_eq({tag, "_mul_a"},     mul_a,     0);
        check_eq({tag, "_mul_b"},     mul_b,     0);
        check_eq({tag, "_busy"},      busy,      0);
        check_eq({tag, "_done"},      done,      0);
    endtask

    // Leaves the bench at the sample point just after the last nibble's edge.
    task automatic load_ops(input int unsigned gap_max, input bit junk_during_compute);
        for (int s = 0; s < 8; s++) begin
            int unsigned gaps;
            gaps = (gap_max != 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_nibble = 4'($urandom);
                tick();
                check_eq("in_ready_gap", in_ready, 1);
            end
            in_valid  = 1'b1;
            in_nibble = 4'(ops[s]);
            check_eq("in_ready_load", in_ready, 1);
            tick();
        end
        in_valid  = junk_during_compute;
        in_nibble = 4'($urandom);
    endtask

    task automatic compute_phase();
        for (int s = 0; s < 8; s++) begin
            int unsigned i;
            int unsigned j;
            int unsigned k;
            i = s / 4;
            j = (s / 2) % 2;
            k = s % 2;
            check_eq("cmp_busy",      busy,      1);
            check_eq("cmp_in_ready",  in_ready,  0);
            check_eq("cmp_out_valid", out_valid, 0);
            check_eq("cmp_mul_a",     mul_a,     ops[i*2 + k]);
            check_eq("cmp_mul_b",     mul_b,     ops[4 + k*2 + j]);
            if (in_valid) in_nibble = 4'($urandom);
            tick();
        end
        // Ninth cycle after the last nibble's edge: results appear.
        check_eq("latency_out_valid", out_valid, 1);
        in_valid = 1'b0;
    endtask

    // mode 0: always ready; 1: pattern 1,0,0,1,...; 2: random.
    task automatic output_phase(input int unsigned mode);
        int unsigned idx;
        int unsigned pc;
        bit r;
        idx = 0;
        pc  = 0;
        while (idx < 4 && pc < 200) begin
            check_eq("out_valid", out_valid, 1);
            check_eq("out_idx",   out_idx,   idx);
            check_eq("out_data",  out_data,  c_ref(idx));
            check_eq("out_done",  done,      0);
            check_eq("out_busy",  busy,      1);
            case (mode)
                0:       r = 1'b1;
                1:       r = (pc % 4 == 0) || (pc % 4 == 3);
                default: r = 1'($urandom);
            endcase
            out_ready = r;
            tick();
            pc++;
            if (r) idx++;
        end
        check_eq("out_all_accepted", idx, 4);
        out_ready = 1'b0;
        check_eq("done_pulse",     done,      1);
        check_eq("post_out_valid", out_valid, 0);
        check_eq("post_in_ready",  in_ready,  1);
        check_eq("post_busy",      busy,      0);
        tick();
        check_eq("done_one_cycle", done, 0);
    endtask

    task automatic run_job(input int unsigned gap_max, input bit junk, input int unsigned mode);
        load_ops(gap_max, junk);
        compute_phase();
        output_phase(mode);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Known operands, full throughput
        set_ops_test1();
        check_eq("ref_c00", c_ref(0), 19);
        run_job(0, 0, 0);

        // Saturated operands: 2*15*15 = 450
        for (int n = 0; n < 8; n++) ops[n] = 15;
        run_job(0, 0, 0);

        // Backpressure pattern
        set_ops_test1();
        run_job(0, 0, 1);

        // Gapped input, in_valid held during compute
        set_ops_test1();
        run_job(2, 1, 0);

        // Abort after five nibbles, then full reload
        for (int n = 0; n < 5; n++) begin
            in_valid  = 1'b1;
            in_nibble = 4'($urandom);
            tick();
        end
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_nibble = 4'd9;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_load_in_ready", in_ready, 1);
        check_eq("clr_load_done",     done,     0);
        check_eq("clr_load_busy",     busy,     0);
        set_ops_test1();
        run_job(0, 0, 0);

        // Abort while presenting index 2
        set_ops_random();
        load_ops(0, 0);
        compute_phase();
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("clr_out_idx_before", out_idx, 2);
        clr = 1'b1;
        tick();
        clr       = 1'b0;
        out_ready = 1'b0;
        check_eq("clr_out_valid",    out_valid, 0);
        check_eq("clr_out_in_ready", in_ready,  1);
        check_eq("clr_out_done",     done,      0);
        check_eq("clr_out_busy",     busy,      0);
        check_eq("clr_out_idx",      out_idx,   0);
        set_ops_random();
        run_job(0, 0, 2);

        // Asynchronous reset at compute step 4
        set_ops_random();
        load_ops(0, 0);
        repeat (4) tick();
        check_eq("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", in_ready, 1);
        set_ops_random();
        run_job(0, 0, 0);

        // Random jobs
        for (int t = 0; t < 8; t++) begin
            set_ops_random();
            run_job($urandom_range(3, 0), 1'($urandom), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matmul2x2_mult_sequencer.md
Name: matmul2x2_mult_sequencer

Overview:
Sequences the shared combinational 4x4 array multiplier to compute a 2x2 by 2x2 unsigned nibble matrix product C = A x B.
- Operands arrive as a nibble-serial valid/ready stream.
- Eight multiply steps are time-multiplexed onto the single multiplier, with accumulation in local registers.
- The four results are then streamed out with valid/ready.
- Sits between the top-level pin interface and the multiplier instance, in place of the direct pin-to-multiplier wiring.

Parameters:
IN_W, 4, operand width; must match the multiplier input width.
ACC_W, 9, accumulator/result width; must be >= 2*IN_W+1 (max sum 2*15*15 = 450).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; return to LOAD, discard progress
in_valid  input  1  nibble present on in_nibble
in_nibble  input  IN_W  operand nibble
in_ready  output  1  block accepts a nibble this cycle
mul_a  output  IN_W  multiplier operand m
mul_b  output  IN_W  multiplier operand q
mul_p  input  2*IN_W  multiplier product (combinational, same cycle)
out_valid  output  1  result present on out_data
out_data  output  ACC_W  result C[i][j]
out_idx  output  2  result index {i,j}
out_ready  input  1  consumer accepts result
busy  output  1  high in COMPUTE or OUTPUT
done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (rst_n low, async):
  - state=LOAD, load count=0, step=0, out index=0.
  - All operand and accumulator registers are 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, mul_a=0, mul_b=0, busy=0, done=0.
- States: LOAD, COMPUTE, OUTPUT. All outputs are decoded from registered state; no input-to-output combinational path except mul_p into the accumulator D input.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 stores in_nibble into slot cnt, then cnt++.
  - Slot order 0..7: A00, A01, A10, A11, B00, B01, B10, B11.
  - On acceptance of slot 7: cnt<=0, step<=0, state<=COMPUTE.
  - in_valid=0 holds all state.
- COMPUTE (exactly 8 cycles, step 0..7):
  - e=step[2:1], k=step[0], i=e[1], j=e[0].
  - mul_a=A[i][k], mul_b=B[k][j].
  - k=0: acc[e] <= zero-extended mul_p. k=1: acc[e] <= acc[e] + mul_p.
  - in_ready=0; in_valid is ignored.
  - After step 7: state<=OUTPUT, out index=0.
  - mul_a and mul_b are 0 in every state other than COMPUTE.
- OUTPUT:
  - out_valid=1, out_data=acc[idx], out_idx=idx.
  - out_data and out_idx are held stable while out_ready=0.
  - out_valid and out_ready both high: idx++.
  - Acceptance at idx=3: state<=LOAD, idx<=0, done=1 for exactly the next cycle (registered).
- Latency: last nibble accepted on edge T; COMPUTE occupies cycles T+1..T+8; out_valid=1 from cycle T+9. Without backpressure, done is high in cycle T+13.
- Operand registers are retained after a product and are overwritten only by the next load. Accumulators are retained until recomputed.
- clr=1 (any state):
  - Next state LOAD; cnt, step and idx cleared; out_valid=0 next cycle; done not asserted.
  - clr has priority over in_valid, out_ready and step advance.
  - A nibble presented in the clr cycle is not stored.
- rst_n asserted mid-operation: immediate return to reset values, including operand and accumulator registers.
- Arithmetic is unsigned. Overflow is impossible with ACC_W >= 9; smaller ACC_W is illegal (elaboration assertion).

Test Plan:
- Reset then load A=[[1,2],[3,4]], B=[[5,6],[7,8]] on consecutive cycles, out_ready=1 -> results (idx,data) = (0,19) (1,22) (2,43) (3,50), first out_valid 9 cycles after the last nibble, done pulse after idx 3.
- Load all nibbles 15 -> every result 450 (9'h1C2); no truncation.
- Same operands as the first test with out_ready toggling 1,0,0,1,... -> each result is held stable while stalled, no index skipped or repeated, done only after idx 3 is accepted.
- Gaps in in_valid during LOAD (e.g. valid every 3rd cycle) -> identical results to the first test. in_valid=1 during COMPUTE -> in_ready=0, no operand corruption.
- clr after 5 nibbles, then a full reload of the first-test operands -> results match the first test, no done pulse from the aborted load. Also clr during OUTPUT at idx 2 -> out_valid drops, in_ready=1 next cycle.
- rst_n pulse low asynchronously at COMPUTE step 4 -> all outputs at reset values immediately. A subsequent full load yields correct results. During COMPUTE, mul_a/mul_b follow the sequence A00/B00, A01/B10, A00/B01, A01/B11, ...
